// File: rtl/dvsd_mul_arbiter_pkg.sv
// Shared constants and types for the shared-multiplier arbiter.
// The multiplier operand width is fixed by dvsd_8216m4.
package dvsd_mul_arbiter_pkg;

    localparam int DW = 8;
    localparam int PW = 2 * DW;

    // Encoding 2'd3 is never entered; the FSM sends it back to IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dvsd_8216m4.sv
// Combinational 8x8 -> 16 unsigned multiplier datapath.
// Full-width product, no truncation.
module dvsd_8216m4 (
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] M
);

    assign M = 16'(A) * 16'(B);

endmodule

// File: rtl/dvsd_rr_arb.sv
// Combinational rotate-priority picker: the first set request at or after
// i_ptr, wrapping modulo NREQ, wins.
module dvsd_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [IDW-1:0]  o_gnt_id,
    output logic            o_gnt_any
);

    int w_best;
    int w_dist;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        o_gnt_any = |i_req;
        o_gnt_id  = '0;
        w_best    = NREQ;
        w_dist    = 0;
        for (int j = 0; j < NREQ; j++) begin
            // Distance from the pointer measured forward around the ring.
            w_dist = (j >= int'(i_ptr)) ? (j - int'(i_ptr)) : (j + NREQ - int'(i_ptr));
            if (i_req[j] && (w_dist < w_best)) begin
                w_best   = w_dist;
                o_gnt_id = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/dvsd_mul_arbiter.sv
// Shares one dvsd_8216m4 multiplier among NREQ requesters with round-robin
// arbitration; responses carry the requester ID.
module dvsd_mul_arbiter
    import dvsd_mul_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [PW-1:0]      rsp_m
);

    state_e         r_state;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_gnt;
    logic [DW-1:0]  r_a;
    logic [DW-1:0]  r_b;
    logic [IDW-1:0] r_rsp_id;
    logic [PW-1:0]  r_rsp_m;

    logic [IDW-1:0] w_gnt_id;
    logic           w_gnt_any;
    logic [PW-1:0]  w_m;
    logic [IDW-1:0] w_next_ptr;

    dvsd_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_req     (req_valid),
        .i_ptr     (r_rr_ptr),
        .o_gnt_id  (w_gnt_id),
        .o_gnt_any (w_gnt_any)
    );

    dvsd_8216m4 u_mul (
        .A (r_a),
        .B (r_b),
        .M (w_m)
    );

    // Grant is offered only while idle and out of reset, so a reset in flight
    // never shows a stray accept.
    always_comb begin
        req_ready = '0;
        if (rst_n && (r_state == S_IDLE) && w_gnt_any) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    assign w_next_ptr = (r_gnt == IDW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_gnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rsp_id <= '0;
            r_rsp_m  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        r_a     <= req_a[w_gnt_id*DW +: DW];
                        r_b     <= req_b[w_gnt_id*DW +: DW];
                        r_gnt   <= w_gnt_id;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_rsp_m  <= w_m;
                    r_rsp_id <= r_gnt;
                    r_state  <= S_RESP;
                end
                S_RESP: begin
                    // Pointer advances only on completion, so the served requester
                    // drops to lowest priority for the next round.
                    if (rsp_ready) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_m     = r_rsp_m;

endmodule

// File: tb/tb_dvsd_mul_arbiter.sv
// Directed self-checking bench for dvsd_mul_arbiter: latency, round-robin
// order, boundary products, backpressure, pointer wrap and mid-flight reset.
module tb_dvsd_mul_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_m;

    logic [7:0]  op_a [NREQ];
    logic [7:0]  op_b [NREQ];
    logic [15:0] sb_m [NREQ];
    logic        sb_pend [NREQ];

    int n_chk;
    int n_err;
    int cyc;
    int n_gnt;
    int n_rsp;
    int gnt_log [16];
    int gnt_cyc [16];
    int rsp_log [16];
    int rsp_cyc [16];

    dvsd_mul_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_m     (rsp_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*8 +: 8] = op_a[i];
            req_b[i*8 +: 8] = op_b[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_chk++;
        n_err++;
        $error("FAIL %s: observed=timeout expected=event", tag);
    endtask

    // Settle, observe one cycle (grants and responses), then advance to just after the next edge.
    task automatic cycle();
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sb_m[i]    = 16'(op_a[i]) * 16'(op_b[i]);
                sb_pend[i] = 1'b1;
                if (n_gnt < 16) begin
                    gnt_log[n_gnt] = i;
                    gnt_cyc[n_gnt] = cyc;
                end
                n_gnt++;
            end
        end
        if (rsp_valid && rsp_ready) begin
            check("sb_pending", 32'(sb_pend[rsp_id]), 32'd1);
            check("sb_product", 32'(rsp_m), 32'(sb_m[rsp_id]));
            sb_pend[rsp_id] = 1'b0;
            if (n_rsp < 16) begin
                rsp_log[n_rsp] = int'(rsp_id);
                rsp_cyc[n_rsp] = cyc;
            end
            n_rsp++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) sb_pend[i] = 1'b0;
    endtask

    task automatic do_single(input int idx, input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] exp_m);
        bit got;
        op_a[idx] = a;
        op_b[idx] = b;
        req_valid = NREQ'(1) << idx;
        rsp_ready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (req_ready[idx]) got = 1'b1;
            cycle();
            if (got) break;
        end
        req_valid = '0;
        if (!got) timeout_fail("single_accept");
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (rsp_valid) begin
                check("single_m", 32'(rsp_m), 32'(exp_m));
                check("single_id", 32'(rsp_id), 32'(idx));
                got = 1'b1;
            end
            cycle();
            if (got) break;
        end
        if (!got) timeout_fail("single_rsp");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; n_gnt = 0; n_rsp = 0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0; op_b[i] = '0; sb_m[i] = '0; sb_pend[i] = 1'b0;
        end
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;

        // Reset state, with every requester asserting
        #2;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_m", 32'(rsp_m), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;

        // 1: single request latency, 12*13
        op_a[0] = 8'd12; op_b[0] = 8'd13;
        req_valid = 4'b0001;
        #1;
        check("t1_ready", 32'(req_ready), 32'h1);
        check("t1_rv_accept", 32'(rsp_valid), 32'd0);
        cycle();
        req_valid = '0;
        #1;
        check("t1_rv_calc", 32'(rsp_valid), 32'd0);
        check("t1_ready_calc", 32'(req_ready), 32'd0);
        cycle();
        #1;
        check("t1_rv_resp", 32'(rsp_valid), 32'd1);
        check("t1_id", 32'(rsp_id), 32'd0);
        check("t1_m", 32'(rsp_m), 32'd156);
        cycle();
        #1;
        check("t1_rv_done", 32'(rsp_valid), 32'd0);

        // 2: all four requesting from reset
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = 8'(i * 10 + 3);
            op_b[i] = 8'(i + 7);
        end
        n_gnt = 0; n_rsp = 0;
        req_valid = 4'b1111;
        repeat (13) cycle();
        req_valid = '0;
        repeat (3) cycle();
        check("t2_n_gnt", 32'(n_gnt), 32'd5);
        check("t2_n_rsp", 32'(n_rsp), 32'd5);
        check("t2_g0", 32'(gnt_log[0]), 32'd0);
        check("t2_g1", 32'(gnt_log[1]), 32'd1);
        check("t2_g2", 32'(gnt_log[2]), 32'd2);
        check("t2_g3", 32'(gnt_log[3]), 32'd3);
        check("t2_g4", 32'(gnt_log[4]), 32'd0);
        check("t2_r1_id", 32'(rsp_log[1]), 32'd1);
        check("t2_r3_id", 32'(rsp_log[3]), 32'd3);
        check("t2_latency", 32'(rsp_cyc[0] - gnt_cyc[0]), 32'd2);
        check("t2_spacing_a", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'd3);
        check("t2_spacing_b", 32'(gnt_cyc[2] - gnt_cyc[1]), 32'd3);

        // 3: boundary operands
        do_single(1, 8'd255, 8'd255, 16'd65025);
        do_single(2, 8'd0,   8'd200, 16'd0);
        do_single(3, 8'd1,   8'd255, 16'd255);

        // 4: backpressure in RESP while others keep requesting
        op_a[0] = 8'd200; op_b[0] = 8'd3;
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        check("t4_ready", 32'(req_ready), 32'h1);
        cycle();
        req_valid = 4'b1111;
        cycle();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t4_hold_rv", 32'(rsp_valid), 32'd1);
            check("t4_hold_m", 32'(rsp_m), 32'd600);
            check("t4_hold_id", 32'(rsp_id), 32'd0);
            check("t4_hold_ready", 32'(req_ready), 32'd0);
            cycle();
        end
        rsp_ready = 1'b1;
        #1;
        check("t4_release_rv", 32'(rsp_valid), 32'd1);
        cycle();
        req_valid = '0;
        #1;
        check("t4_done_rv", 32'(rsp_valid), 32'd0);

        // 5: requesters 3 and 0 held, pointer primed to 3
        do_reset();
        do_single(2, 8'd5, 8'd6, 16'd30);
        op_a[3] = 8'd17; op_b[3] = 8'd19;
        op_a[0] = 8'd128; op_b[0] = 8'd2;
        n_gnt = 0; n_rsp = 0;
        req_valid = 4'b1001;
        repeat (12) cycle();
        req_valid = '0;
        repeat (3) cycle();
        check("t5_n_gnt", 32'(n_gnt), 32'd4);
        check("t5_g0", 32'(gnt_log[0]), 32'd3);
        check("t5_g1", 32'(gnt_log[1]), 32'd0);
        check("t5_g2", 32'(gnt_log[2]), 32'd3);
        check("t5_g3", 32'(gnt_log[3]), 32'd0);
        check("t5_n_rsp", 32'(n_rsp), 32'd4);

        // 6: reset during CALC, pointer previously at 2
        do_reset();
        do_single(1, 8'd7, 8'd9, 16'd63);
        op_a[2] = 8'd11; op_b[2] = 8'd11;
        req_valid = 4'b0100;
        #1;
        check("t6_ready", 32'(req_ready), 32'h4);
        cycle();
        rst_n = 1'b0;
        #1;
        check("t6_rst_rv", 32'(rsp_valid), 32'd0);
        check("t6_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) sb_pend[i] = 1'b0;
        n_rsp = 0;
        repeat (4) cycle();
        check("t6_no_rsp", 32'(n_rsp), 32'd0);
        req_valid = 4'b1111;
        #1;
        check("t6_first_gnt", 32'(req_ready), 32'h1);
        cycle();
        req_valid = '0;
        repeat (3) cycle();
        check("t6_rsp_after", 32'(n_rsp), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
